// File: rtl/ttl_reg_pkg.sv
// Shared types, mode constants and helpers for the TTL octal register/latch bank.
package ttl_reg_pkg;

   localparam int unsigned MODE_EDGE  = 0;
   localparam int unsigned MODE_LATCH = 1;
   localparam int unsigned MAX_WIDTH  = 64;

   // Per-channel control bundle (strobe, active-low gate, output control)
   typedef struct packed {
      logic strb;
      logic gn;
      logic ocn;
   } chan_ctrl_t;

   // Capture is suppressed for exactly one clock after reset release
   typedef enum logic {
      ST_ARM = 1'b0,
      ST_RUN = 1'b1
   } arm_state_t;

   // All-ones of the requested width, models a pulled-up bus when outputs are off
   function automatic logic [MAX_WIDTH-1:0] default_off_val(input int unsigned width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
         if (b < width) v[b] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/ttl_reg_chan.sv
// One TTL register/latch channel: strobe conditioning, edge detect, storage, output mux.
// Optional strobe synchroniser + majority glitch filter under TTL_REG_STROBE_FILTER_EN.
module ttl_reg_chan
   import ttl_reg_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      MODE      = MODE_EDGE,
   parameter bit               EDGE_RISE = 1'b1,
   parameter logic [WIDTH-1:0] OFF_VAL   = WIDTH'(default_off_val(WIDTH)),
   parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  chan_ctrl_t       ctrl,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_c,
   output logic             cap
);

   logic             strb_eff;
   logic             strb_d;
   logic [WIDTH-1:0] data;
   arm_state_t       state;
   arm_state_t       state_nxt;
   logic             fire_c;
   logic             write_c;

`ifdef TTL_REG_STROBE_FILTER_EN
   logic [1:0] sync;
   logic [1:0] hist;

   // Two-flop synchroniser then three-sample majority; idle-high after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '1;
         hist <= '1;
      end else begin
         sync <= {sync[0], ctrl.strb};
         hist <= {hist[0], sync[1]};
      end
   end

   assign strb_eff = majority3(sync[1], hist[0], hist[1]);
`else
   assign strb_eff = ctrl.strb;
`endif

   // Reset-release arming state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_ARM;
      else        state <= state_nxt;
   end

   // Write decision: edge mode fires on the selected transition, latch mode on level
   always_comb begin
      state_nxt = state;
      fire_c    = 1'b0;
      write_c   = 1'b0;
      if (MODE == MODE_LATCH)  fire_c = strb_eff;
      else if (EDGE_RISE)      fire_c = strb_eff & ~strb_d;
      else                     fire_c = ~strb_eff & strb_d;
      case (state)
         ST_ARM:  state_nxt = ST_RUN;
         ST_RUN:  write_c   = fire_c & ~ctrl.gn;
         default: state_nxt = ST_ARM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_d <= 1'b1;
         cap    <= 1'b0;
         data   <= RST_VAL;
      end else begin
         strb_d <= strb_eff;
         cap    <= write_c;
         if (write_c) data <= d;
      end
   end

   // Output enable does not gate capture, only what the bus sees
   assign q_c = ctrl.ocn ? OFF_VAL : data;

endmodule

// File: rtl/ttl_reg_bank_sync.sv
// Bank of NCH independent clock-synchronous 74LS374/377/373-style registers.
// Define TTL_REG_STROBE_FILTER_EN to add a synchroniser + glitch filter on each strobe.
module ttl_reg_bank_sync
   import ttl_reg_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      NCH       = 1,
   parameter int unsigned      MODE      = MODE_EDGE,
   parameter bit               EDGE_RISE = 1'b1,
   parameter logic [WIDTH-1:0] OFF_VAL   = WIDTH'(default_off_val(WIDTH)),
   parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       strb,
   input  logic [NCH-1:0]       gn,
   input  logic [NCH-1:0]       OCn,
   input  logic [NCH*WIDTH-1:0] D,
   output logic [NCH*WIDTH-1:0] Q,
   output logic [NCH-1:0]       cap
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      chan_ctrl_t ctrl;

      assign ctrl = '{strb: strb[i], gn: gn[i], ocn: OCn[i]};

      ttl_reg_chan #(
         .WIDTH     (WIDTH),
         .MODE      (MODE),
         .EDGE_RISE (EDGE_RISE),
         .OFF_VAL   (OFF_VAL),
         .RST_VAL   (RST_VAL)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .ctrl  (ctrl),
         .d     (D[i*WIDTH +: WIDTH]),
         .q_c   (Q[i*WIDTH +: WIDTH]),
         .cap   (cap[i])
      );
   end

endmodule

// File: tb/tb_ttl_reg_bank_sync.sv
// Bench for ttl_reg_bank_sync: directed tables/sequences plus random stimulus vs. a behavioural model.
module tb_ttl_reg_bank_sync;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 2;
   localparam int unsigned NI = 3;   // 0: edge/rise, 1: latch, 2: edge/fall
`ifdef TTL_REG_STROBE_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   strb [NI];
   logic [N-1:0]   gn   [NI];
   logic [N-1:0]   ocn  [NI];
   logic [N*W-1:0] d    [NI];
   logic [N*W-1:0] q    [NI];
   logic [N-1:0]   cap  [NI];

   int total = 0;
   int bad   = 0;

   ttl_reg_bank_sync #(.WIDTH(W), .NCH(N), .MODE(0), .EDGE_RISE(1'b1)) dut_e (
      .clk(clk), .rst_n(rst_n), .strb(strb[0]), .gn(gn[0]), .OCn(ocn[0]),
      .D(d[0]), .Q(q[0]), .cap(cap[0]));
   ttl_reg_bank_sync #(.WIDTH(W), .NCH(N), .MODE(1), .EDGE_RISE(1'b1)) dut_l (
      .clk(clk), .rst_n(rst_n), .strb(strb[1]), .gn(gn[1]), .OCn(ocn[1]),
      .D(d[1]), .Q(q[1]), .cap(cap[1]));
   ttl_reg_bank_sync #(.WIDTH(W), .NCH(N), .MODE(0), .EDGE_RISE(1'b0)) dut_f (
      .clk(clk), .rst_n(rst_n), .strb(strb[2]), .gn(gn[2]), .OCn(ocn[2]),
      .D(d[2]), .Q(q[2]), .cap(cap[2]));

   // Behavioural model: register contents, last cap, previous effective strobe, raw strobe history
   logic [W-1:0] m_reg  [NI][N];
   logic         m_cap  [NI][N];
   logic         m_prev [NI][N];
   logic [3:0]   m_hist [NI][N];
   bit           m_first;

   task automatic model_reset();
      for (int i = 0; i < NI; i++)
         for (int c = 0; c < N; c++) begin
            m_reg[i][c]  = 8'h00;
            m_cap[i][c]  = 1'b0;
            m_prev[i][c] = 1'b1;
            m_hist[i][c] = 4'hF;
         end
      m_first = 1'b1;
   endtask

   // Applies one clock's worth of the rules using the inputs about to be sampled
   task automatic model_clock();
      logic s, eff, wr, a, b, e;
      for (int i = 0; i < NI; i++)
         for (int c = 0; c < N; c++) begin
            s = strb[i][c];
            a = m_hist[i][c][1]; b = m_hist[i][c][2]; e = m_hist[i][c][3];
            eff = FILT ? ((32'(a) + 32'(b) + 32'(e)) >= 2) : s;
            if (m_first)    wr = 1'b0;
            else if (i == 1) wr = eff & ~gn[i][c];
            else if (i == 0) wr = eff & ~m_prev[i][c] & ~gn[i][c];
            else             wr = ~eff & m_prev[i][c] & ~gn[i][c];
            if (wr) m_reg[i][c] = d[i][c*W +: W];
            m_cap[i][c]  = wr;
            m_prev[i][c] = eff;
            m_hist[i][c] = {m_hist[i][c][2:0], s};
         end
      m_first = 1'b0;
   endtask

   task automatic tick();
      model_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] aq, input logic [W-1:0] eq,
                      input logic ac, input logic ec);
      total++;
      if (aq !== eq || ac !== ec) begin
         bad++;
         $display("FAIL %s: q=%h cap=%b, expected q=%h cap=%b", name, aq, ac, eq, ec);
      end
   endtask

   task automatic check_all(input string tag);
      logic [W-1:0] eq;
      for (int i = 0; i < NI; i++)
         for (int c = 0; c < N; c++) begin
            eq = ocn[i][c] ? 8'hFF : m_reg[i][c];
            chk($sformatf("%s i%0d c%0d", tag, i, c), q[i][c*W +: W], eq, cap[i][c], m_cap[i][c]);
         end
   endtask

   task automatic set_in(input int i, input int c, input logic s, input logic g,
                         input logic o, input logic [W-1:0] dv);
      strb[i][c] = s;
      gn[i][c]   = g;
      ocn[i][c]  = o;
      d[i][c*W +: W] = dv;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < NI; i++) begin
         strb[i] = '0; gn[i] = '0; ocn[i] = '0; d[i] = '0;
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   typedef struct {
      logic         s;
      logic         g;
      logic         o;
      logic [W-1:0] dv;
      logic [W-1:0] eq;
      logic         ec;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h5A, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h5A, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h22, 8'h5A, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'hC3, 8'h5A, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'hC3, 8'h5A, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'hC3, 8'h5A, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h81, 8'hFF, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h81, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h81, 8'hFF, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0};

      clear_inputs();
      #2;
      do_reset("reset0");

`ifndef TTL_REG_STROBE_FILTER_EN
      // Capture, hold-high, gated edge, OCn during capture on the rising-edge instance
      for (int k = 0; k < 12; k++) begin
         set_in(0, 0, tbl[k].s, tbl[k].g, tbl[k].o, tbl[k].dv);
         tick();
         chk($sformatf("tbl%0d", k), q[0][W-1:0], tbl[k].eq, cap[0][0], tbl[k].ec);
      end
      ocn[0][0] = 1'b1; #1;
      chk("ocn_hi_now", q[0][W-1:0], 8'hFF, cap[0][0], 1'b0);
      ocn[0][0] = 1'b0; #1;
      chk("ocn_lo_now", q[0][W-1:0], 8'h81, cap[0][0], 1'b0);

      // Reset released with strobe already high must not capture
      set_in(0, 0, 1'b1, 1'b0, 1'b0, 8'h33);
      rst_n = 1'b0; #1;
      model_reset();
      chk("rst_async", q[0][W-1:0], 8'h00, cap[0][0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_rel1", q[0][W-1:0], 8'h00, cap[0][0], 1'b0);
      tick();
      chk("rst_rel2", q[0][W-1:0], 8'h00, cap[0][0], 1'b0);
      strb[0][0] = 1'b0;
      tick();
      chk("rst_low", q[0][W-1:0], 8'h00, cap[0][0], 1'b0);
      strb[0][0] = 1'b1;
      tick();
      chk("rst_rise", q[0][W-1:0], 8'h33, cap[0][0], 1'b1);

      // Latch instance ch1 follows D; falling-edge instance ch0 captures only on 1->0
      clear_inputs();
      strb[2][0] = 1'b1;
      do_reset("reset1");
      tick();
      set_in(1, 1, 1'b1, 1'b0, 1'b0, 8'h01); set_in(2, 0, 1'b1, 1'b0, 1'b0, 8'hA5);
      tick();
      chk("lat_01", q[1][2*W-1:W], 8'h01, cap[1][1], 1'b1);
      chk("fall_hi", q[2][W-1:0], 8'h00, cap[2][0], 1'b0);
      set_in(1, 1, 1'b1, 1'b0, 1'b0, 8'h02); set_in(2, 0, 1'b0, 1'b0, 1'b0, 8'hA5);
      tick();
      chk("lat_02", q[1][2*W-1:W], 8'h02, cap[1][1], 1'b1);
      chk("fall_cap", q[2][W-1:0], 8'hA5, cap[2][0], 1'b1);
      set_in(1, 1, 1'b1, 1'b0, 1'b0, 8'h03); set_in(2, 0, 1'b1, 1'b0, 1'b0, 8'h5A);
      tick();
      chk("lat_03", q[1][2*W-1:W], 8'h03, cap[1][1], 1'b1);
      chk("fall_rise", q[2][W-1:0], 8'hA5, cap[2][0], 1'b0);
      set_in(1, 1, 1'b0, 1'b0, 1'b0, 8'h04);
      tick();
      chk("lat_fall", q[1][2*W-1:W], 8'h03, cap[1][1], 1'b0);
      set_in(1, 1, 1'b0, 1'b0, 1'b0, 8'h05);
      tick();
      chk("lat_hold", q[1][2*W-1:W], 8'h03, cap[1][1], 1'b0);
      chk("lat_ch0", q[1][W-1:0], 8'h00, cap[1][0], 1'b0);
      chk("fall_hold", q[2][W-1:0], 8'hA5, cap[2][0], 1'b0);
`else
      // Filtered strobe: single-clock glitch rejected, 3-clock pulse captured on the 4th clock
      repeat (6) tick();
      set_in(0, 0, 1'b1, 1'b0, 1'b0, 8'h55);
      tick();
      chk("glitch0", q[0][W-1:0], 8'h00, cap[0][0], 1'b0);
      strb[0][0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("glitch%0d", k + 1), q[0][W-1:0], 8'h00, cap[0][0], 1'b0);
      end
      set_in(0, 0, 1'b1, 1'b0, 1'b0, 8'h7E);
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 3) strb[0][0] = 1'b0;
         chk($sformatf("filt_lat%0d", k), q[0][W-1:0], (k < 4) ? 8'h00 : 8'h7E,
             cap[0][0], (k == 4));
      end
      tick();
      chk("filt_hold", q[0][W-1:0], 8'h7E, cap[0][0], 1'b0);
`endif

      // Random stimulus on all instances against the model
      for (int r = 0; r < 2; r++) begin
         clear_inputs();
         do_reset($sformatf("rnd_rst%0d", r));
         for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NI; i++) begin
               strb[i] = N'($urandom);
               gn[i]   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
               ocn[i]  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
               d[i]    = (N*W)'($urandom);
            end
            tick();
            check_all($sformatf("rnd%0d_%0d", r, n));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ttl_reg_bank_sync.md
Name: ttl_reg_bank_sync

Overview:
- Parametrised, clock-synchronous model of a bank of TTL octal registers/latches: 74LS374 edge-triggered, 74LS377 enable-gated and 74LS373 transparent styles.
- NCH independent channels of WIDTH bits, each with its own strobe, gate and output-control inputs.
- Each strobe is sampled on the system clock and edge-detected.
- Used wherever board-level register or latch chips sit on a CPU/video bus in the arcade core.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 1, number of independent channels.
- MODE, 0, 0 = edge-triggered (374/377), 1 = transparent latch (373).
- EDGE_RISE, 1, 1 = capture on strobe 0->1, 0 = capture on 1->0 (MODE 0 only).
- OFF_VAL, all ones, value driven on Q while its OCn is high (models pulled-up bus).
- RST_VAL, 0, register content after reset.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- strb, in, NCH, per-channel clock/latch-enable (374 CLK, 373 LE), sampled on clk.
- gn, in, NCH, per-channel active-low gate (377 G); tie 0 for plain 374/373.
- OCn, in, NCH, per-channel output control; high forces OFF_VAL.
- D, in, NCH*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
- Q, out, NCH*WIDTH, same packing.
- cap, out, NCH, one-clk pulse when the channel's register content was written this cycle.

Behaviour:
- Reset: asynchronous assertion and synchronous effect on the next clk after release.
  - reg[i] = RST_VAL, strb_d[i] = 1, cap = 0.
  - Q = RST_VAL, or OFF_VAL where OCn is high.
  - A reset mid-capture aborts it; no capture occurs on the first clk after release, even if strb is high.
- Edge detect: strb_d[i] <= strb[i] every clk.
  - EDGE_RISE = 1: edge = strb & ~strb_d.
  - EDGE_RISE = 0: edge = ~strb & strb_d.
- MODE 0:
  - On clk where edge[i] and gn[i] = 0: reg[i] <= D[i], cap[i] = 1 next cycle.
  - New Q is visible one clk after the edge sample.
  - Edge while gn[i] = 1: ignored, not deferred.
  - Strobe held static: no further captures.
- MODE 1:
  - While strb[i] = 1 and gn[i] = 0: reg[i] <= D[i] every clk, so Q follows D with 1 clk latency; cap[i] = 1 on each such clk.
  - On the clk where strb falls: the value sampled that clk, with strb already low, is not written; reg holds the last D sampled while strb was high.
  - EDGE_RISE is ignored.
- Output: Q[i] = OCn[i] ? OFF_VAL : reg[i], purely combinational.
  - OCn does not affect capture; a capture while OCn = 1 still updates reg.
- Channels are fully independent; simultaneous edges on several channels all capture in the same clk.
- No Hi-Z anywhere; OFF_VAL replaces it.

Optional Feature:
- Macro: TTL_REG_STROBE_FILTER_EN.
- Defined:
  - Each strb passes a 2-flop synchroniser plus a 3-sample majority glitch filter before edge detect.
  - Capture latency grows from 1 to 4 clk after the strb change.
  - Single-clk strobe glitches are rejected.
  - Filter flops reset to 1.
- Undefined: strb is used directly as described above (latency 1 clk).

Decomposition:
- Package ttl_reg_pkg:
  - localparams MODE_EDGE = 0, MODE_LATCH = 1.
  - Function for the default OFF_VAL (all ones of WIDTH).
- Sub-module ttl_reg_chan: one channel containing edge detect, optional filter, storage and output mux.
- Top level instantiates NCH of ttl_reg_chan in a generate loop and packs the buses.

Test Plan:
1. Reset, then ch0 strb 0->1 with D = 0x5A, gn = 0, OCn = 0 -> one clk later Q = 0x5A, cap[0] pulses for exactly 1 clk; strb held high with D = 0x11 -> Q stays 0x5A, no further cap.
2. rst_n released while strb = 1, D = 0x33 -> Q = RST_VAL (0x00), no cap; after strb 1->0->1 -> Q = 0x33.
3. MODE 0, gn = 1, rising strb with D = 0xC3 -> Q unchanged, cap = 0; gn -> 0 with strb still high -> still no capture.
4. OCn = 1 during capture of D = 0x81 -> Q = 0xFF; OCn -> 0 -> Q = 0x81 immediately.
5. NCH = 2, MODE 1: ch1 strb high, D stepping 0x01, 0x02, 0x03, then strb low with D = 0x04 -> Q follows with 1 clk lag and holds 0x03; meanwhile ch0 falling-edge instance (EDGE_RISE = 0) captures 0xA5 on 1->0 only.
6. With TTL_REG_STROBE_FILTER_EN defined: 1-clk strb pulse -> no capture; strb high for 3 clk with D = 0x7E -> Q = 0x7E 4 clk after the rise.
